sys_ctrl: RTL
=============

Name: sys_ctrl

Overview:
- Command-decoding controller that sits upstream of the 8x16 register file.
- Consumes byte frames from the UART RX path and drives the register file's write/read port.
- Sequences ALU operations with the ALU clock gate; operands are stored in register-file addresses 0/1, which feed the ALU.
- Pushes read data and ALU results into the TX FIFO.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX/register-file data
- ADDR_WIDTH, 4, register-file address width
- ALU_OUT_WIDTH, 16, ALU result width; sent as two bytes
- TIMEOUT_CYCLES, 1023, idle-gap limit inside a frame (used only with CMD_TIMEOUT_EN)

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-low reset
- RX_P_DATA  input  8  received byte
- RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid
- RdData  input  8  register-file read data
- RdData_Valid  input  1  register-file read data valid
- ALU_OUT  input  16  ALU result
- ALU_OUT_VALID  input  1  ALU result valid
- FIFO_FULL  input  1  TX FIFO full
- Address  output  4  register-file address
- WrEn  output  1  register-file write strobe
- RdEn  output  1  register-file read strobe
- WrData  output  8  register-file write data
- ALU_FUN  output  4  ALU function select
- ALU_EN  output  1  ALU start strobe
- CLK_GATE_EN  output  1  ALU clock-gate enable
- TX_P_DATA  output  8  byte to TX FIFO
- TX_D_VLD  output  1  TX FIFO write strobe

Behaviour:
- All outputs are registered. Reset values: every output is 0; the FSM state is IDLE; the captured address and result registers are 0.
- Command bytes, decoded only in IDLE on RX_D_VLD:
  - 0xAA: write register; frame is addr, data.
  - 0xBB: read register; frame is addr.
  - 0xCC: ALU with operands; frame is A, B, fun.
  - 0xDD: ALU without operands; frame is fun.
  - Any other byte is dropped and the FSM stays in IDLE.
- WrEn, RdEn, ALU_EN and TX_D_VLD are single-cycle pulses. Address and WrData hold their last value between pulses.
- States and transitions:
  - IDLE -> WR_ADDR on 0xAA, RD_ADDR on 0xBB, OP_A on 0xCC, ALU_FUN on 0xDD.
  - WR_ADDR: on the next strobe, latch RX_P_DATA[3:0] as the address -> WR_DATA.
  - WR_DATA: on the strobe, in the cycle after that edge: WrEn=1, Address=latched address, WrData=byte. Then -> IDLE.
  - RD_ADDR: on the strobe, in the next cycle: RdEn=1, Address=RX_P_DATA[3:0]. Then -> RD_WAIT.
  - RD_WAIT: on RdData_Valid, capture RdData -> TX_RD.
  - OP_A: on the strobe, WrEn=1, Address=0, WrData=byte -> OP_B.
  - OP_B: on the strobe, same with Address=1 -> ALU_FUN.
  - ALU_FUN: CLK_GATE_EN is driven 1 from entry into this state. On the strobe: ALU_FUN=RX_P_DATA[3:0], ALU_EN=1 -> ALU_WAIT.
  - ALU_WAIT: on ALU_OUT_VALID, capture ALU_OUT and drop CLK_GATE_EN -> TX_LO.
  - TX_RD, TX_LO, TX_HI: when FIFO_FULL=0, TX_D_VLD=1 with the byte. TX_LO sends ALU_OUT[7:0] then -> TX_HI. TX_HI sends ALU_OUT[15:8]. TX_RD and TX_HI -> IDLE.
  - While FIFO_FULL=1 the FSM holds in its TX state, TX_D_VLD stays 0 and no byte is lost.
- Latency:
  - Last frame byte to WrEn: 1 cycle.
  - RdData_Valid to TX_D_VLD: 1 cycle (FIFO not full).
  - ALU_OUT_VALID to first TX_D_VLD: 1 cycle; second byte follows in the next cycle.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state is ignored (byte dropped).
- A RdData_Valid or ALU_OUT_VALID that is not expected is ignored.
- Reset asserted mid-frame returns to IDLE immediately (asynchronously). A partial frame is discarded, with no write or TX.

Optional Feature:
- CMD_TIMEOUT_EN defined: a gap counter runs in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN.
  - The counter clears on each RX_D_VLD.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE, clears CLK_GATE_EN and issues no strobes.
  - The wait states (RD_WAIT, ALU_WAIT) and TX states are never timed out.
- Not defined: no counter; frames wait indefinitely for their next byte.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - the state enum;
  - command constants CMD_REG_WR=8'hAA, CMD_REG_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - operand addresses OPA_ADDR=0, OPB_ADDR=1.
- No sub-module by default. With CMD_TIMEOUT_EN, the gap counter is the sub-module sys_ctrl_timeout.

Test Plan:
- Write: bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=3C, one cycle after the 3C strobe; no TX.
- Read: write register 5=3C, then BB,05 -> RdEn pulse with Address=5; model returns 3C with RdData_Valid -> TX_D_VLD with TX_P_DATA=3C.
- ALU: CC,10,20,00 -> WrEn to Address 0 with 10, then to Address 1 with 20; ALU_EN with ALU_FUN=0; CLK_GATE_EN high until ALU_OUT_VALID; ALU_OUT=0030 -> TX bytes 30 then 00.
- Backpressure: DD,02 with ALU_OUT=1234 and FIFO_FULL held high 5 cycles -> no TX_D_VLD while full, then 34 then 12.
- Robustness: stray byte 7E in IDLE -> no strobes; reset during OP_B -> all outputs 0, the following AA frame executes normally.
- With CMD_TIMEOUT_EN: AA,05 then silence for TIMEOUT_CYCLES -> back to IDLE; a later 3C byte produces no WrEn.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared constants, state encoding and helpers for sys_ctrl
//
// Contents:
//   - command bytes that open a frame
//   - register-file addresses of the two ALU operands
//   - the controller state encoding
//   - in_frame(): states in which the controller waits for another frame byte
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_REG_WR  = 8'hAA;
    localparam logic [7:0] CMD_REG_RD  = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] OPA_ADDR = 4'd0;
    localparam logic [3:0] OPB_ADDR = 4'd1;

    localparam int FUN_WIDTH = 4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_RD    = 4'd9,
        ST_TX_LO    = 4'd10,
        ST_TX_HI    = 4'd11
    } state_e;

    // States that are waiting on the next RX byte of a partially received frame.
    function automatic logic in_frame(input state_e s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
               (s == ST_OP_A)    || (s == ST_OP_B)    || (s == ST_ALU_FUN);
    endfunction

endpackage

// File: rtl/sys_ctrl_timeout.sv
// rtl/sys_ctrl_timeout.sv - inter-byte gap counter for sys_ctrl (used with CMD_TIMEOUT_EN)
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   active_i   controller is inside a frame, waiting for a byte
//   clear_i    an RX byte arrived this cycle
//   expired_o  gap has reached TIMEOUT_CYCLES; controller must abandon the frame
module sys_ctrl_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic CLK,
    input  logic RST,
    input  logic active_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte arriving in the same cycle always wins over expiry.
    assign expired_o = active_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - command-decoding controller between UART RX, register file, ALU and TX FIFO
//
// Optional feature macro: CMD_TIMEOUT_EN (abandon a frame after TIMEOUT_CYCLES idle cycles)
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD           received byte and its one-cycle strobe
//   RdData, RdData_Valid          register-file read return
//   ALU_OUT, ALU_OUT_VALID        ALU result return
//   FIFO_FULL                     TX FIFO back-pressure
//   Address, WrEn, RdEn, WrData   register-file port
//   ALU_FUN, ALU_EN, CLK_GATE_EN  ALU control
//   TX_P_DATA, TX_D_VLD           TX FIFO write port
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
    logic [ADDR_WIDTH-1:0]    address_q, address_d;
    logic [DATA_WIDTH-1:0]    wrdata_q, wrdata_d;
    logic [FUN_WIDTH-1:0]     fun_q, fun_d;
    logic [DATA_WIDTH-1:0]    txdata_q, txdata_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic                     gate_q, gate_d;
    logic                     tx_vld_q, tx_vld_d;
    logic                     timeout_w;

`ifdef CMD_TIMEOUT_EN
    sys_ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .active_i  (in_frame(state_q)),
        .clear_i   (RX_D_VLD),
        .expired_o (timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        result_d  = result_q;
        address_d = address_q;
        wrdata_d  = wrdata_q;
        fun_d     = fun_q;
        txdata_d  = txdata_q;
        gate_d    = gate_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_REG_WR:  state_d = ST_WR_ADDR;
                        CMD_REG_RD:  state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_OP_A;
                        CMD_ALU_NOP: begin
                            state_d = ST_ALU_FUN;
                            gate_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wrdata_d  = RX_P_DATA;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_d   = 1'b1;
                    addr_d    = RX_P_DATA[ADDR_WIDTH-1:0];
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = ST_RD_WAIT;
                end
            end
            // Read data is forwarded straight to TX when the FIFO has room, so
            // TX_D_VLD follows RdData_Valid by one cycle; otherwise park in TX_RD.
            ST_RD_WAIT: begin
                if (RdData_Valid) begin
                    result_d = ALU_OUT_WIDTH'(RdData);
                    if (!FIFO_FULL) begin
                        tx_vld_d = 1'b1;
                        txdata_d = RdData;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_TX_RD;
                    end
                end
            end
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(OPA_ADDR);
                    wrdata_d  = RX_P_DATA;
                    state_d   = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(OPB_ADDR);
                    wrdata_d  = RX_P_DATA;
                    gate_d    = 1'b1;
                    state_d   = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    fun_d    = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d = 1'b1;
                    state_d  = ST_ALU_WAIT;
                end
            end
            // Same bypass as the read path: low byte goes out the cycle after the result.
            ST_ALU_WAIT: begin
                if (ALU_OUT_VALID) begin
                    result_d = ALU_OUT;
                    gate_d   = 1'b0;
                    if (!FIFO_FULL) begin
                        tx_vld_d = 1'b1;
                        txdata_d = ALU_OUT[DATA_WIDTH-1:0];
                        state_d  = ST_TX_HI;
                    end else begin
                        state_d  = ST_TX_LO;
                    end
                end
            end
            ST_TX_RD: begin
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    txdata_d = result_q[DATA_WIDTH-1:0];
                    state_d  = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    txdata_d = result_q[DATA_WIDTH-1:0];
                    state_d  = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    txdata_d = result_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only fires in frame states with no byte this cycle, so no strobe is lost.
        if (timeout_w) begin
            state_d = ST_IDLE;
            gate_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            result_q  <= '0;
            address_q <= '0;
            wrdata_q  <= '0;
            fun_q     <= '0;
            txdata_q  <= '0;
            gate_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            result_q  <= result_d;
            address_q <= address_d;
            wrdata_q  <= wrdata_d;
            fun_q     <= fun_d;
            txdata_q  <= txdata_d;
            gate_q    <= gate_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign Address     = address_q;
    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign WrData      = wrdata_q;
    assign ALU_FUN     = fun_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = txdata_q;
    assign TX_D_VLD    = tx_vld_q;

endmodule
